// File: rtl/weight_mem_loader_pkg.sv
// Shared encodings for the weight memory loader: FSM states and error codes.
package weight_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_EARLY_LAST = 2'b01;
  localparam logic [1:0] ERR_NO_LAST    = 2'b10;

endpackage

// File: rtl/weight_mem_loader.sv
// Streams weight words into one neuron's weight memory as registered single-word writes.
// state | meaning
// IDLE  | waiting for cfg_start, tready low
// LOAD  | accepting words, busy high, one write per accepted word
// DONE  | single cycle: done pulse, final write visible
module weight_mem_loader
  import weight_mem_loader_pkg::*;
#(
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int numWeight    = 784,
  parameter int idWidth      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [idWidth-1:0]      cfg_layer,
  input  logic [idWidth-1:0]      cfg_neuron,
  input  logic [dataWidth-1:0]    s_weight_tdata,
  input  logic                    s_weight_tvalid,
  input  logic                    s_weight_tlast,
  output logic                    s_weight_tready,
  output logic                    wen,
  output logic [addressWidth:0]   waddr,
  output logic [dataWidth-1:0]    win,
  output logic [idWidth-1:0]      wlayer,
  output logic [idWidth-1:0]      wneuron,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err
);

  localparam int CW = addressWidth + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(numWeight - 1);

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_err;
  logic [idWidth-1:0]    r_layer;
  logic [idWidth-1:0]    r_neuron;
  logic                  r_wen;
  logic [CW-1:0]         r_waddr;
  logic [dataWidth-1:0]  r_win;
  logic                  w_accept;
  logic                  w_end;

  // Reset asserts immediately but releases two clocks later, aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_accept = (r_state == ST_LOAD) && s_weight_tvalid;
  assign w_end    = w_accept && ((r_cnt == LAST_IDX) || s_weight_tlast);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (cfg_start) w_state_nxt = ST_LOAD;
      ST_LOAD: if (w_end)     w_state_nxt = ST_DONE;
      ST_DONE:                w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt    <= '0;
      r_err    <= ERR_NONE;
      r_layer  <= '0;
      r_neuron <= '0;
      r_wen    <= 1'b0;
      r_waddr  <= '0;
      r_win    <= '0;
    end else begin
      if ((r_state == ST_IDLE) && cfg_start) begin
        r_layer  <= cfg_layer;
        r_neuron <= cfg_neuron;
        r_cnt    <= '0;
        r_err    <= ERR_NONE;
      end
      // The counter stops at numWeight because tready falls with the last accept.
      if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST_IDX) begin
          if (!s_weight_tlast) r_err <= ERR_NO_LAST;
        end else if (s_weight_tlast) begin
          r_err <= ERR_EARLY_LAST;
        end
      end
      r_wen   <= w_accept;
      r_waddr <= w_accept ? r_cnt : '0;
      r_win   <= w_accept ? s_weight_tdata : '0;
    end
  end

  assign s_weight_tready = (r_state == ST_LOAD);
  assign busy            = (r_state == ST_LOAD);
  assign done            = (r_state == ST_DONE);
  assign wen             = r_wen;
  assign waddr           = r_waddr;
  assign win             = r_win;
  assign wlayer          = r_layer;
  assign wneuron         = r_neuron;
  assign err             = r_err;

endmodule

// File: tb/tb_weight_mem_loader.sv
// Scoreboard bench for weight_mem_loader: a load model queues expected writes and
// completion records, a monitor compares them against the memory-side outputs.
module tb_weight_mem_loader;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int NW = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [IW-1:0] cfg_layer = '0;
  logic [IW-1:0] cfg_neuron = '0;
  logic [DW-1:0] s_weight_tdata = '0;
  logic          s_weight_tvalid = 1'b0;
  logic          s_weight_tlast = 1'b0;
  logic          s_weight_tready;
  logic          wen;
  logic [AW:0]   waddr;
  logic [DW-1:0] win;
  logic [IW-1:0] wlayer;
  logic [IW-1:0] wneuron;
  logic          busy;
  logic          done;
  logic [1:0]    err;

  weight_mem_loader #(
    .addressWidth(AW), .dataWidth(DW), .numWeight(NW), .idWidth(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_layer(cfg_layer),
    .cfg_neuron(cfg_neuron), .s_weight_tdata(s_weight_tdata),
    .s_weight_tvalid(s_weight_tvalid), .s_weight_tlast(s_weight_tlast),
    .s_weight_tready(s_weight_tready), .wen(wen), .waddr(waddr), .win(win),
    .wlayer(wlayer), .wneuron(wneuron), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]    err;
    logic [IW-1:0] layer;
    logic [IW-1:0] neuron;
  } dn_t;

  wr_t  exp_wr[$];
  dn_t  exp_dn[$];
  wr_t  m_wr;
  dn_t  m_dn;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_acc = 1'b0;

  logic [DW-1:0] w_data[8];
  logic          w_last[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a write must follow each handshake by exactly one cycle and match the queue.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      prev_acc = 1'b0;
    end else begin
      check("wen_latency", 32'(wen), 32'(prev_acc));
      if (wen) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 32'(waddr), 32'hFFFF_FFFF);
        end else begin
          m_wr = exp_wr.pop_front();
          check("waddr", 32'(waddr), 32'(m_wr.addr));
          check("win", 32'(win), 32'(m_wr.data));
        end
      end else begin
        check("waddr_zero_when_idle", 32'(waddr), 32'd0);
        check("win_zero_when_idle", 32'(win), 32'd0);
      end
      if (done) begin
        check("last_wen_with_done", 32'(wen), 32'd1);
        if (exp_dn.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          m_dn = exp_dn.pop_front();
          check("err", 32'(err), 32'(m_dn.err));
          check("wlayer", 32'(wlayer), 32'(m_dn.layer));
          check("wneuron", 32'(wneuron), 32'(m_dn.neuron));
        end
      end
      prev_acc = s_weight_tvalid && s_weight_tready;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"}, 32'(wen), 32'd0);
    check({tag, "_waddr"}, 32'(waddr), 32'd0);
    check({tag, "_win"}, 32'(win), 32'd0);
    check({tag, "_wlayer"}, 32'(wlayer), 32'd0);
    check({tag, "_wneuron"}, 32'(wneuron), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_tready"}, 32'(s_weight_tready), 32'd0);
  endtask

  // vmode: 0 = tvalid held, 1 = every other cycle, 2 = random.
  task automatic run_load(input logic [IW-1:0] lay, input logic [IW-1:0] neu, input int nw,
                          input int vmode, input bit inject, input int abort_after);
    int k;
    int acc;
    int cyc;
    logic vld;
    logic rdy;
    logic [1:0] e;
    dn_t d;
    wr_t w;
    // Reference: words are taken in order until tlast or numWeight words, whichever first.
    k = 0;
    while (k < nw) begin
      k++;
      if (w_last[k-1] || k == NW) break;
    end
    if (k == NW) e = w_last[k-1] ? 2'b00 : 2'b10;
    else         e = 2'b01;
    if (abort_after > 0) k = abort_after;
    for (int i = 0; i < k; i++) begin
      w.addr = (AW+1)'(i);
      w.data = w_data[i];
      exp_wr.push_back(w);
    end
    if (abort_after == 0) begin
      d.err = e; d.layer = lay; d.neuron = neu;
      exp_dn.push_back(d);
    end

    @(negedge clk);
    cfg_start = 1'b1; cfg_layer = lay; cfg_neuron = neu;
    @(negedge clk);
    cfg_start = 1'b0; cfg_layer = 8'($urandom); cfg_neuron = 8'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);

    acc = 0; cyc = 0;
    while (!done && cyc < 200) begin
      case (vmode)
        0:       vld = (acc < nw);
        1:       vld = (acc < nw) && (cyc % 2 == 0);
        default: vld = (acc < nw) && ($urandom_range(0, 2) != 0);
      endcase
      s_weight_tvalid = vld;
      s_weight_tdata  = vld ? w_data[acc] : '0;
      s_weight_tlast  = vld ? w_last[acc] : 1'b0;
      if (inject && cyc == 1) begin
        cfg_start = 1'b1; cfg_layer = 8'd9; cfg_neuron = 8'd5;
      end else begin
        cfg_start = 1'b0;
      end
      rdy = s_weight_tready;
      @(posedge clk);
      if (vld && rdy) acc++;
      if (abort_after > 0 && acc == abort_after) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        s_weight_tvalid = 1'b0;
        cfg_start = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    cfg_start = 1'b0;
    if (cyc >= 200) check("load_timeout", 32'(cyc), 32'd0);
    // Leave any surplus word presented into the following cycle; it must not be taken.
    @(negedge clk);
    check("tready_after_done", 32'(s_weight_tready), 32'd0);
    check("err_hold", 32'(err), 32'(e));
    check("wlayer_hold", 32'(wlayer), 32'(lay));
    s_weight_tvalid = 1'b0;
    s_weight_tlast = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_seq(input int n);
    for (int i = 0; i < 8; i++) begin
      w_data[i] = 16'h0011 + 16'(i);
      w_last[i] = 1'b0;
    end
    if (n > 0) w_last[n-1] = 1'b1;
  endtask

  initial begin
    int lp;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check_all_zero("post_reset");

    // tvalid while idle must not produce a write
    @(negedge clk);
    s_weight_tvalid = 1'b1; s_weight_tdata = 16'hBEEF;
    repeat (3) begin
      @(negedge clk);
      check("idle_tready", 32'(s_weight_tready), 32'd0);
    end
    s_weight_tvalid = 1'b0;

    fill_seq(4); run_load(8'd1, 8'd38, 4, 0, 1'b0, 0);
    fill_seq(4); run_load(8'd1, 8'd38, 4, 1, 1'b0, 0);
    fill_seq(2); run_load(8'd1, 8'd38, 2, 0, 1'b0, 0);
    fill_seq(0); run_load(8'd1, 8'd38, 5, 0, 1'b0, 0);
    fill_seq(4); run_load(8'd1, 8'd38, 4, 0, 1'b1, 0);
    fill_seq(4); run_load(8'd2, 8'd7, 4, 0, 1'b0, 2);
    fill_seq(4); run_load(8'd3, 8'd11, 4, 0, 1'b0, 0);

    for (int t = 0; t < 10; t++) begin
      lp = $urandom_range(0, 4);
      for (int i = 0; i < 8; i++) begin
        w_data[i] = 16'($urandom);
        w_last[i] = 1'b0;
      end
      if (lp < 4) w_last[lp] = 1'b1;
      run_load(8'($urandom), 8'($urandom), (lp < 4) ? lp + 1 : 5, 2, 1'b0, 0);
    end

    repeat (4) @(negedge clk);
    check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    check("dones_outstanding", 32'(exp_dn.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
